uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Flow-controlled UART receiver for the RS-232 port behind the ADM3222. It deserializes 8N1 frames from `uart_rxd` into a first-word-fall-through FIFO and presents bytes on the codebase's req/ready handshake. It drives `uart_rts` from FIFO occupancy so a CTS-aware peer stops sending before bytes are lost. It is the receive-side counterpart of the CTS-respecting transmit path and replaces the tied-high RTS in the board top.

## Interface

- `BAUD`, 115200, line bit rate.
- `CLK_HZ`, 25000000, `clk` frequency.
- `DEPTH`, 16, FIFO entries; must be a power of 2, ≥4.
- `RTS_MARGIN`, 4, free entries remaining at which RTS drops.
- `clk`  in  1  single clock, all logic rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `uart_rxd`  in  1  asynchronous serial input, idle high.
- `uart_rts`  out  1  1 = peer may send, 0 = peer must pause.
- `rx_req`  out  1  FIFO non-empty, `rx_data` valid.
- `rx_ready`  in  1  consumer accepts `rx_data` this cycle.
- `rx_data`  out  8  FIFO head byte.
- `fill`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled 0.
- `overrun`  out  1  one-cycle pulse: valid byte dropped, FIFO full.

## Operation

- Bit period is `DIV = (CLK_HZ + BAUD/2) / BAUD`, which is 217 at the defaults. The counter is wide enough for `DIV`.
- `uart_rxd` passes through a 2-flop synchronizer. Both flops reset to 1. All logic uses the synchronized value `rxd_s`.
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: when `rxd_s` is 0, load the counter with `DIV/2` and go to START.
  - START: when the counter expires, sample `rxd_s`. If 1, treat it as a glitch and return to IDLE. If 0, load `DIV` and go to DATA.
  - DATA: sample once every `DIV` cycles, LSB first, into a shift register. After bit 7, load `DIV` and go to STOP.
  - STOP: when the counter expires, sample `rxd_s`.
    - If 1: push the byte, or pulse `overrun` if the push is refused, then go to IDLE.
    - If 0: pulse `frame_err`, drop the byte, go to BREAK.
  - BREAK: stay until `rxd_s` is 1, then go to IDLE. A held-low line yields exactly one `frame_err`.
- FIFO:
  - `rx_req = (fill != 0)` and `rx_data` = head entry.
  - A pop occurs when `rx_req && rx_ready`. `rx_ready` while empty is ignored.
  - A push is accepted when `fill < DEPTH` or a pop occurs in the same cycle.
  - A simultaneous push and pop leaves `fill` unchanged.
  - Pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`.
- RTS, registered with hysteresis:
  - Clears to 0 when the next `fill ≥ DEPTH − RTS_MARGIN`.
  - Sets to 1 when the next `fill ≤ DEPTH/2`.
  - Otherwise holds its value.
- Reset values:
  - `uart_rts`=1, `rx_req`=0, `fill`=0, `frame_err`=0, `overrun`=0, FSM=IDLE.
  - `rx_data` is don't-care while `rx_req`=0.
- Reset mid-frame abandons the partial byte and empties the FIFO. If the line is still low after reset, IDLE treats it as a start bit. No error pulse is generated.

## Timing

- Stop bit is sampled `DIV/2 + 9·DIV` cycles after the falling edge reaches `rxd_s`. The `rxd_s` falling edge itself lags the pin by 2 cycles.
- The push happens in the stop-sample cycle. `rx_req` rises and `fill` increments on the next cycle.
- The FSM returns to IDLE in the cycle after the stop sample, so a back-to-back start bit is caught about DIV/2 early.
- `uart_rts` updates in the same cycle as `fill`, with 1-cycle latency from the push or pop.
- `frame_err` and `overrun` are each high for exactly 1 cycle, in the cycle after the stop sample.
- A pop makes the next entry visible on `rx_data` the following cycle.

## Test plan

- Single byte at defaults: send 0xA5 with `rx_ready`=0.
  - Required: `rx_req` rises the cycle after the stop sample, `rx_data`=0xA5, `fill`=1.
  - Pulse `rx_ready` for 1 cycle: `rx_req`=0 and `fill`=0 the next cycle.
- Back-to-back stream: send 0x00, 0xFF, 0x55 with zero idle bits while `rx_ready`=1.
  - Required: three pops in order, with no `frame_err` or `overrun`.
- RTS hysteresis: send 12 bytes with `rx_ready`=0.
  - Required: `uart_rts` drops to 0 the cycle `fill` becomes 12.
  - Pop 3 bytes (`fill`=9): `uart_rts` stays 0.
  - Pop 1 more (`fill`=8): `uart_rts`=1.
- Overrun: with `rx_ready`=0, send 17 bytes 0x01..0x11.
  - Required: `fill`=16, and one `overrun` pulse on the 17th byte.
  - Draining yields 0x01..0x10.
  - Repeat the 17th byte with a pop in its stop-sample cycle: byte accepted, no `overrun`, `fill` stays 16.
- Framing and break:
  - Send 0x3C with stop bit 0: one `frame_err`, `fill` unchanged.
  - Hold the line low for 30 bit times, then release and send 0x7E: exactly one `frame_err`, then 0x7E received.
  - A start glitch of DIV/4 cycles produces no byte.
- Reset mid-frame: assert `reset` for 1 cycle during bit 4, with 3 bytes queued.
  - Required: `fill`=0, `rx_req`=0, `uart_rts`=1 the next cycle, and no error pulses.
  - A following clean 0xC3 is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - 8N1 UART receiver feeding a FWFT FIFO with RTS flow control
//
// Purpose: deserializes 8N1 frames from uart_rxd into a first-word-fall-through
// FIFO, presents bytes on the rx_req/rx_ready handshake and drives uart_rts
// from FIFO occupancy so a CTS-aware peer pauses before bytes are lost.
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   synchronous active-high reset
//   uart_rxd   in   asynchronous serial input, idle high
//   uart_rts   out  1 = peer may send, 0 = peer must pause
//   rx_req     out  FIFO non-empty, rx_data valid
//   rx_ready   in   consumer accepts rx_data this cycle
//   rx_data    out  FIFO head byte
//   fill       out  current FIFO occupancy
//   frame_err  out  one-cycle pulse, stop bit sampled 0
//   overrun    out  one-cycle pulse, valid byte dropped because FIFO full

module uart_rx_fifo #(
  parameter int BAUD       = 115200,
  parameter int CLK_HZ     = 25000000,
  parameter int DEPTH      = 16,
  parameter int RTS_MARGIN = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     uart_rxd,
  output logic                     uart_rts,
  output logic                     rx_req,
  input  logic                     rx_ready,
  output logic [7:0]               rx_data,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     frame_err,
  output logic                     overrun
);

  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CW  = $clog2(DIV + 1);
  localparam int AW  = $clog2(DEPTH);
  localparam int FW  = AW + 1;

  localparam logic [CW-1:0] DIV_FULL = CW'(DIV);
  localparam logic [CW-1:0] DIV_HALF = CW'(DIV / 2);
  localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);
  localparam logic [FW-1:0] RTS_CLR  = FW'(DEPTH - RTS_MARGIN);
  localparam logic [FW-1:0] RTS_SET  = FW'(DEPTH / 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  // Two-flop synchronizer; both flops reset to the idle (high) line level
  logic rxd_m;
  logic rxd_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= uart_rxd;
      rxd_s <= rxd_m;
    end
  end

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          bit_tick;

  // Counter expires on the cycle it holds 1, giving exactly N cycles per load of N
  assign bit_tick = (cnt == CW'(1));

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [FW-1:0] fill_next;
  logic          push_req;
  logic          push_ok;
  logic          pop;

  // The push is issued combinationally in the stop-sample cycle so the byte
  // lands in the FIFO on the same edge the stop bit is judged good.
  assign push_req = (state == S_STOP) && bit_tick && rxd_s;
  assign pop      = rx_req && rx_ready;
  // A full FIFO still takes the byte if the head leaves on the same edge
  assign push_ok  = push_req && ((fill != FILL_MAX) || pop);

  assign rx_req   = (fill != '0);
  assign rx_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!rxd_s) begin
            cnt   <= DIV_HALF;
            state <= S_START;
          end
        end
        S_START: begin
          if (bit_tick) begin
            if (rxd_s) begin
              state <= S_IDLE;
            end else begin
              cnt     <= DIV_FULL;
              bit_idx <= '0;
              state   <= S_DATA;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_DATA: begin
          if (bit_tick) begin
            shreg   <= {rxd_s, shreg[7:1]};
            cnt     <= DIV_FULL;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_STOP: begin
          if (bit_tick) begin
            if (rxd_s) begin
              if (!push_ok) begin
                overrun <= 1'b1;
              end
              state <= S_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= S_BREAK;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_BREAK: begin
          // Wait out a held-low line so a break reports only one error
          if (rxd_s) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    fill_next = fill;
    if (push_ok && !pop) begin
      fill_next = fill + FW'(1);
    end else if (pop && !push_ok) begin
      fill_next = fill - FW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= shreg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill     <= '0;
      uart_rts <= 1'b1;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      fill <= fill_next;
      // Hysteresis band between the two thresholds holds the last value
      if (fill_next >= RTS_CLR) begin
        uart_rts <= 1'b0;
      end else if (fill_next <= RTS_SET) begin
        uart_rts <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo at default parameters
module tb_uart_rx_fifo;

  localparam int DIV   = (25000000 + 115200 / 2) / 115200;
  localparam int DEPTH = 16;
  // Pin falling edge -> stop-sample edge: 2 synchronizer flops, 1 IDLE detect
  // cycle, half a bit to the start-bit centre, then 9 full bits.
  localparam int STOP_OFS = 3 + DIV / 2 + 9 * DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       uart_rxd = 1'b1;
  logic       rx_ready = 1'b0;
  logic       uart_rts;
  logic       rx_req;
  logic [7:0] rx_data;
  logic [4:0] fill;
  logic       frame_err;
  logic       overrun;

  uart_rx_fifo dut (
    .clk       (clk),
    .reset     (reset),
    .uart_rxd  (uart_rxd),
    .uart_rts  (uart_rts),
    .rx_req    (rx_req),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .fill      (fill),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #20 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int exp_fe = 0;
  int exp_ov = 0;
  logic [7:0] exp_q[$];

  logic pre_req, post_req, pre_rts, post_rts;
  int   pre_fill, post_fill;
  bit   rnd_run;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted handshake pops the scoreboard; pulses are counted
  initial begin
    forever begin
      @(negedge clk);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (rx_req && rx_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL pop_unexpected: got 0x%0h, want no byte", rx_data);
        end else begin
          check("pop_data", int'(rx_data), int'(exp_q.pop_front()));
        end
      end
    end
  end

  // One 8N1 frame. The reference model decides the outcome up front: a bad
  // stop bit is a framing error, otherwise the byte is queued if the FIFO
  // model has room (or a pop coincides with the stop sample), else overrun.
  task automatic send(input logic [7:0] b, input logic stop_bit, input bit pop_at_stop);
    if (!stop_bit) exp_fe++;
    else if (exp_q.size() < DEPTH || pop_at_stop) exp_q.push_back(b);
    else exp_ov++;
    uart_rxd = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      tick(DIV);
    end
    uart_rxd = stop_bit;
    tick(STOP_OFS - 9 * DIV - 1);
    pre_req  = rx_req;
    pre_fill = int'(fill);
    pre_rts  = uart_rts;
    if (pop_at_stop) rx_ready = 1'b1;
    tick(1);
    if (pop_at_stop) rx_ready = 1'b0;
    post_req  = rx_req;
    post_fill = int'(fill);
    post_rts  = uart_rts;
    tick(10 * DIV - STOP_OFS);
    uart_rxd = 1'b1;
  endtask

  task automatic pop1();
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  task automatic drain(input string name);
    rx_ready = 1'b1;
    tick(DEPTH + 2);
    rx_ready = 1'b0;
    check({name, "_fill"}, int'(fill), 0);
    check({name, "_all_popped"}, exp_q.size(), 0);
  endtask

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: got cycle limit, want $finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rb;

    reset = 1'b1;
    tick(4);
    check("rst_rts", int'(uart_rts), 1);
    check("rst_req", int'(rx_req), 0);
    check("rst_fill", int'(fill), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_overrun", int'(overrun), 0);
    reset = 1'b0;
    tick(DIV);

    // Single byte, handshake held off
    send(8'hA5, 1'b1, 1'b0);
    check("a5_req_in_stop_cycle", int'(pre_req), 0);
    check("a5_req_after_stop", int'(post_req), 1);
    check("a5_fill", post_fill, 1);
    check("a5_data", int'(rx_data), 8'hA5);
    pop1();
    check("a5_req_after_pop", int'(rx_req), 0);
    check("a5_fill_after_pop", int'(fill), 0);

    // Back-to-back stream with consumer always ready
    rx_ready = 1'b1;
    send(8'h00, 1'b1, 1'b0);
    send(8'hFF, 1'b1, 1'b0);
    send(8'h55, 1'b1, 1'b0);
    tick(4);
    rx_ready = 1'b0;
    check("stream_all_popped", exp_q.size(), 0);
    check("stream_frame_err", fe_cnt, exp_fe);
    check("stream_overrun", ov_cnt, exp_ov);

    // Fill 0x01..0x11 with no consumer: RTS drop at 12, full at 16, overrun on 17
    for (int v = 1; v <= 17; v++) begin
      send(8'(v), 1'b1, 1'b0);
      if (v == 11) check("rts_at_11", int'(post_rts), 1);
      if (v == 12) begin
        check("rts_before_12", int'(pre_rts), 1);
        check("fill_before_12", pre_fill, 11);
        check("fill_at_12", post_fill, 12);
        check("rts_at_12", int'(post_rts), 0);
      end
    end
    check("full_fill", int'(fill), DEPTH);
    check("full_overrun", ov_cnt, exp_ov);
    check("full_rts", int'(uart_rts), 0);

    // Same byte again, head popped in the stop-sample cycle: accepted
    send(8'h11, 1'b1, 1'b1);
    check("coinc_fill", post_fill, DEPTH);
    check("coinc_overrun", ov_cnt, exp_ov);

    // RTS hysteresis on the way down
    for (int i = 0; i < 7; i++) pop1();
    check("hyst_fill_9", int'(fill), 9);
    check("hyst_rts_9", int'(uart_rts), 0);
    pop1();
    check("hyst_fill_8", int'(fill), 8);
    check("hyst_rts_8", int'(uart_rts), 1);
    drain("drain_full");

    // Framing error, then a 30-bit break, then a clean byte
    send(8'h3C, 1'b0, 1'b0);
    tick(DIV);
    check("frame_err_count", fe_cnt, exp_fe);
    check("frame_fill", int'(fill), 0);
    uart_rxd = 1'b0;
    exp_fe++;
    tick(30 * DIV);
    uart_rxd = 1'b1;
    tick(2 * DIV);
    check("break_frame_err", fe_cnt, exp_fe);
    rx_ready = 1'b1;
    send(8'h7E, 1'b1, 1'b0);
    tick(4);
    rx_ready = 1'b0;
    check("break_7e_popped", exp_q.size(), 0);
    check("break_frame_err_after", fe_cnt, exp_fe);

    // Start glitch shorter than half a bit
    uart_rxd = 1'b0;
    tick(DIV / 4);
    uart_rxd = 1'b1;
    tick(12 * DIV);
    check("glitch_fill", int'(fill), 0);
    check("glitch_frame_err", fe_cnt, exp_fe);

    // Reset during bit 4 with three random bytes queued
    for (int i = 0; i < 3; i++) send(8'($urandom), 1'b1, 1'b0);
    check("preq_fill", int'(fill), 3);
    rb = 8'($urandom);
    uart_rxd = 1'b0;
    tick(DIV);
    for (int i = 0; i < 4; i++) begin
      uart_rxd = rb[i];
      tick(DIV);
    end
    uart_rxd = rb[4];
    tick(DIV / 2);
    reset = 1'b1;
    uart_rxd = 1'b1;
    tick(1);
    reset = 1'b0;
    exp_q.delete();
    check("midrst_fill", int'(fill), 0);
    check("midrst_req", int'(rx_req), 0);
    check("midrst_rts", int'(uart_rts), 1);
    tick(2 * DIV);
    check("midrst_frame_err", fe_cnt, exp_fe);
    check("midrst_overrun", ov_cnt, exp_ov);
    rx_ready = 1'b1;
    send(8'hC3, 1'b1, 1'b0);
    tick(4);
    rx_ready = 1'b0;
    check("midrst_c3_popped", exp_q.size(), 0);

    // Random bytes under a randomly stalling consumer
    rnd_run = 1'b1;
    fork
      begin
        while (rnd_run) begin
          rx_ready = 1'($urandom_range(0, 1));
          tick(1);
        end
      end
      begin
        for (int i = 0; i < 2; i++) send(8'($urandom), 1'b1, 1'b0);
        rnd_run = 1'b0;
      end
    join
    drain("drain_rand");
    check("final_frame_err", fe_cnt, exp_fe);
    check("final_overrun", ov_cnt, exp_ov);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
